// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the gshare branch predictor.
//   - state_t / ST_INIT / ST_RUN : controller states (table sweep, normal run)
//   - ctr_reset_val / ctr_max_val : saturating-counter constants for a given width
//   - pht_index / btb_index / btb_tag : PC hashing helpers. Results are returned
//     32 bits wide; callers size-cast them to the table index or tag width.
package bp_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Weakly-not-taken: one below the midpoint, so the MSB reads as not taken.
  function automatic logic [31:0] ctr_reset_val(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] ctr_max_val(input int unsigned ctr_bits);
    return (32'd1 << ctr_bits) - 32'd1;
  endfunction

  // Word-aligned PC bits XORed with the zero-extended global history.
  function automatic logic [31:0] pht_index(input logic [31:0] pc,
                                            input logic [31:0] hist,
                                            input int unsigned idx_bits);
    return ((pc >> 2) ^ hist) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] btb_index(input logic [31:0] pc,
                                            input int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // Tag is the PC field directly above the BTB index bits.
  function automatic logic [31:0] btb_tag(input logic [31:0] pc,
                                          input int unsigned idx_bits,
                                          input int unsigned tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/sat_ctr.sv
// sat_ctr: next-value logic for one saturating up/down counter.
//   value : current counter value
//   inc   : count up (held at the maximum)
//   dec   : count down (held at zero); ignored when inc is also set
//   next  : updated counter value
module sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max_val(CTR_BITS));

  always_comb begin
    next = value;
    if (inc) begin
      if (value != CTR_MAX) next = value + 1'b1;
    end else if (dec) begin
      if (value != '0) next = value - 1'b1;
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor with a
// direct-mapped BTB.
//   clk, rst (sync, active-low)      : clock and reset
//   ready                            : tables initialised, predictor active
//   pred_req, pred_pc                : fetch PC; pred_req marks a consumed prediction
//   pred_taken, pred_target          : combinational prediction for pred_pc
//   pred_hist                        : GHR snapshot carried down the fetch pipe
//   upd_valid, upd_pc, upd_taken,
//   upd_target, upd_hist,
//   upd_mispredict                   : resolved-branch training interface
//   stat_mispred                     : saturating mispredict counter
// After reset the controller sweeps every table entry once (one per cycle)
// before asserting ready; all requests are ignored during the sweep.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS  = 7,
  parameter int HIST_BITS = 7,
  parameter int TAG_BITS  = 8,
  parameter int CTR_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 pred_req,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_mispredict,
  output logic [31:0]          stat_mispred
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(ctr_reset_val(CTR_BITS));

  // Control state
  state_t                r_state;
  logic [IDX_BITS-1:0]   r_init_ptr;
  logic [HIST_BITS-1:0]  r_ghr;
  logic [31:0]           r_stat;

  // Tables (initialised by the sweep, not by reset)
  logic [CTR_BITS-1:0]   r_pht     [DEPTH];
  logic                  r_btb_vld [DEPTH];
  logic [TAG_BITS-1:0]   r_btb_tag [DEPTH];
  logic [31:0]           r_btb_tgt [DEPTH];

  logic                  w_run;
  logic [IDX_BITS-1:0]   w_pred_pidx;
  logic [IDX_BITS-1:0]   w_pred_bidx;
  logic [TAG_BITS-1:0]   w_pred_tag;
  logic [CTR_BITS-1:0]   w_pred_ctr;
  logic                  w_pred_hit;
  logic [IDX_BITS-1:0]   w_upd_pidx;
  logic [IDX_BITS-1:0]   w_upd_bidx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic [CTR_BITS-1:0]   w_upd_ctr;
  logic [CTR_BITS-1:0]   w_ctr_next;
  logic                  w_upd_we;

  assign w_run = (r_state == ST_RUN);

  // Lookup: tables are read combinationally, so a same-cycle update is seen
  // only from the following cycle.
  assign w_pred_pidx = IDX_BITS'(pht_index(pred_pc, 32'(r_ghr), IDX_BITS));
  assign w_pred_bidx = IDX_BITS'(btb_index(pred_pc, IDX_BITS));
  assign w_pred_tag  = TAG_BITS'(btb_tag(pred_pc, IDX_BITS, TAG_BITS));
  assign w_pred_ctr  = r_pht[w_pred_pidx];
  assign w_pred_hit  = r_btb_vld[w_pred_bidx] && (r_btb_tag[w_pred_bidx] == w_pred_tag);

  assign pred_taken  = w_run && w_pred_ctr[CTR_BITS-1] && w_pred_hit;
  assign pred_target = pred_taken ? r_btb_tgt[w_pred_bidx] : (pred_pc + 32'd4);
  assign pred_hist   = r_ghr;
  assign ready       = w_run;
  assign stat_mispred = r_stat;

  // Training uses the history snapshot the branch was predicted with.
  assign w_upd_pidx = IDX_BITS'(pht_index(upd_pc, 32'(upd_hist), IDX_BITS));
  assign w_upd_bidx = IDX_BITS'(btb_index(upd_pc, IDX_BITS));
  assign w_upd_tag  = TAG_BITS'(btb_tag(upd_pc, IDX_BITS, TAG_BITS));
  assign w_upd_ctr  = r_pht[w_upd_pidx];
  assign w_upd_we   = w_run && upd_valid;

  sat_ctr #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_ctr (
    .value (w_upd_ctr),
    .inc   (upd_taken),
    .dec   (!upd_taken),
    .next  (w_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
      r_ghr      <= '0;
      r_stat     <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (r_init_ptr == '1) r_state <= ST_RUN;
        end
        default: begin
          // A mispredict repairs history from the snapshot and overrides
          // the speculative shift of the current fetch.
          if (upd_valid && upd_mispredict) begin
            r_ghr <= HIST_BITS'({upd_hist, upd_taken});
          end else if (pred_req) begin
            r_ghr <= HIST_BITS'({r_ghr, pred_taken});
          end
          if (upd_valid && upd_mispredict && (r_stat != 32'hFFFF_FFFF)) begin
            r_stat <= r_stat + 32'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_pht[r_init_ptr]     <= CTR_INIT;
      r_btb_vld[r_init_ptr] <= 1'b0;
    end else if (w_upd_we) begin
      r_pht[w_upd_pidx] <= w_ctr_next;
      // Only taken branches carry a meaningful target.
      if (upd_taken) begin
        r_btb_vld[w_upd_bidx] <= 1'b1;
        r_btb_tag[w_upd_bidx] <= w_upd_tag;
        r_btb_tgt[w_upd_bidx] <= upd_target;
      end
    end
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter IDX_BITS, default 7, meaning log2 of pattern-table and BTB depth.
REQ-002 The block SHALL have parameter HIST_BITS, default 7, meaning global history length (1..IDX_BITS).
REQ-003 The block SHALL have parameter TAG_BITS, default 8, meaning BTB tag width.
REQ-004 The block SHALL have parameter CTR_BITS, default 2, meaning saturating-counter width (>=2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port ready, output, 1 bit: table initialisation complete.
REQ-008 The block SHALL have port pred_req, input, 1 bit: a prediction is consumed this cycle.
REQ-009 The block SHALL have port pred_pc, input, 32 bits: fetch PC.
REQ-010 The block SHALL have port pred_taken, output, 1 bit: predicted direction.
REQ-011 The block SHALL have port pred_target, output, 32 bits: predicted next PC.
REQ-012 The block SHALL have port pred_hist, output, HIST_BITS: GHR snapshot for the fetch pipeline to carry.
REQ-013 The block SHALL have port upd_valid, input, 1 bit: branch resolved this cycle.
REQ-014 The block SHALL have ports upd_pc (32 bits), upd_taken (1 bit), upd_target (32 bits), upd_hist (HIST_BITS) and upd_mispredict (1 bit), all inputs, carrying the resolved branch, its snapshot and a mispredict flag.
REQ-015 The block SHALL have port stat_mispred, output, 32 bits: saturating mispredict count.

Function
REQ-016 Pattern index SHALL be pc[IDX_BITS+1:2] XOR zero-extended history; BTB index SHALL be pc[IDX_BITS+1:2] unhashed; tag SHALL be pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
REQ-017 Prediction SHALL be combinational from pred_pc and current state; pred_taken = counter MSB AND BTB valid AND tag match.
REQ-018 pred_target SHALL be the BTB target when pred_taken, else pred_pc+4 (mod 2^32).
REQ-019 pred_hist SHALL equal GHR before any shift in that cycle.
REQ-020 On pred_req && ready, the GHR SHALL become {GHR[HIST_BITS-2:0], pred_taken}.
REQ-021 On upd_valid && upd_mispredict && ready, the GHR SHALL become {upd_hist[HIST_BITS-2:0], upd_taken}; this SHALL take priority over REQ-020 in the same cycle.
REQ-022 On upd_valid && ready, the counter at the index hashed with upd_hist SHALL saturate-increment if upd_taken, else saturate-decrement.
REQ-023 On upd_valid && upd_taken && ready, the BTB entry SHALL be written: valid=1, tag, upd_target; not-taken updates SHALL leave the BTB unchanged.
REQ-024 A same-cycle read and write of one entry SHALL return the old value; the new value SHALL be visible the next cycle.
REQ-025 stat_mispred SHALL increment on upd_valid && upd_mispredict && ready and saturate at 0xFFFFFFFF.
REQ-026 The FSM SHALL have states INIT and RUN; INIT writes one entry per cycle (counter=2^(CTR_BITS-1)-1, BTB valid=0) with pointer 0..2^IDX_BITS-1, then enters RUN.
REQ-027 During INIT, ready=0 and pred_taken=0, and pred_req/upd_valid SHALL be ignored.

Reset
REQ-028 While rst=0: state=INIT, init pointer=0, GHR=0, stat_mispred=0, ready=0.
REQ-029 rst low mid-sweep or in RUN SHALL restart the sweep from entry 0; ready SHALL rise exactly 2^IDX_BITS cycles after rst returns high.

Structure
REQ-030 Package bp_pkg SHALL hold the FSM state type, counter reset/maximum constants and the index/tag hashing functions.
REQ-031 Saturating counter update SHALL be a sub-module sat_ctr (parameter CTR_BITS; inputs value, inc, dec; output next).

Verification
REQ-032 Release rst -> ready=0 for 128 cycles, then 1; every pred_pc gives pred_taken=0 and pred_target=pc+4.
REQ-033 Two taken updates pc=0x100, target=0x400, hist=0 (GHR held 0) -> pred_pc=0x100 gives taken=1, target=0x400.
REQ-034 Predict with GHR=0x55, pred_req=1, pred_taken=1 -> pred_hist=0x55 and GHR=0x2B next cycle.
REQ-035 Same cycle pred_req plus mispredict update with upd_hist=0x10, upd_taken=0 -> GHR=0x20 and stat_mispred +1.
REQ-036 Taken update pc=0x100 then predict pc=0x100+(1<<(IDX_BITS+2)) (same index, different tag) -> pred_taken=0.
REQ-037 Assert rst mid-INIT at pointer 50 -> sweep restarts; ready rises 128 cycles after release.
